uart_speed_receiver: RTL

Receive side of the speed-reporting UART link: deserialises the 8N1 stream emitted by the ETC transmitter path and reassembles each two-byte speed record into a `WIDTH_SPEED`-bit value with a one-cycle valid strobe. It sits at the far end of `serial_data_out`, for example in the roadside logger or a loopback test harness, and runs from the system clock with its own 16x oversampling tick.

---
 rtl/uart_speed_receiver_pkg.sv | 22 ++
 rtl/uart_speed_receiver_if.sv | 40 ++++
 rtl/uart_speed_receiver_rx.sv | 151 +++++++++++++++
 rtl/uart_speed_receiver.sv | 100 ++++++++++
 4 files changed

// File: rtl/uart_speed_receiver_pkg.sv
// Shared types and constants for the speed-record UART receive path.
// Each character carries a position flag in its top bit and a 7-bit payload.
package uart_pkg;

    localparam int UART_DATA_SIZE = 8;
    localparam int HDR_BIT        = 7;
    localparam int PAYLOAD_BITS   = UART_DATA_SIZE - 1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic {
        ASM_WAIT_HI,
        ASM_WAIT_LO
    } asm_state_t;

endpackage

// File: rtl/uart_speed_receiver_if.sv
// Bundle of the receiver's line input, record outputs and FSM debug taps.
// The slave side is the receiver; the master side drives the line and watches results.
interface uart_speed_receiver_if
    import uart_pkg::*;
#(
    parameter int WIDTH_SPEED = 14
);
    logic                   serial_data_in;
    logic [WIDTH_SPEED-1:0] speed;
    logic                   speed_valid;
    logic                   frame_error;
    logic                   sync_error;
    logic                   rx_busy;
    rx_state_t              byte_state_dbg;
    asm_state_t             asm_state_dbg;

    // speed_valid, frame_error and sync_error are single-cycle strobes with no
    // ready/backpressure: the consumer must take each one on the cycle it is high.
    modport slave (
        input  serial_data_in,
        output speed,
        output speed_valid,
        output frame_error,
        output sync_error,
        output rx_busy,
        output byte_state_dbg,
        output asm_state_dbg
    );

    modport master (
        output serial_data_in,
        input  speed,
        input  speed_valid,
        input  frame_error,
        input  sync_error,
        input  rx_busy,
        input  byte_state_dbg,
        input  asm_state_dbg
    );
endinterface

// File: rtl/uart_speed_receiver_rx.sv
// 8N1 character receiver: line synchroniser, free-running oversample tick and byte FSM.
// Emits one-cycle byte_valid with rx_data, or frame_error when the stop bit is low.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int SAMPLE    = 16,
    parameter int BAUD_DVSR = 271
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_data_in,
    output logic [DATA_SIZE-1:0] rx_data,
    output logic                 byte_valid,
    output logic                 frame_error,
    output logic                 rx_busy,
    output rx_state_t            state_dbg
);
    localparam int BW = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
    localparam int SW = $clog2(SAMPLE);
    localparam int NW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DVSR - 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(SAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(SAMPLE - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_SIZE - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_line_d;
    logic [BW-1:0]        r_baud_cnt;
    rx_state_t            r_state;
    logic [SW-1:0]        r_s_cnt;
    logic [NW-1:0]        r_n_cnt;
    logic [DATA_SIZE-1:0] r_shift;
    logic [DATA_SIZE-1:0] r_rx_data;
    logic                 r_byte_valid;
    logic                 r_frame_error;

    logic w_fall;
    logic w_tick;

    // Line flops reset to the idle level so leaving reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_line_d <= 1'b1;
        end else begin
            r_sync1  <= serial_data_in;
            r_sync2  <= r_sync1;
            r_line_d <= r_sync2;
        end
    end

    assign w_fall = r_line_d & ~r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud_cnt <= '0;
        end else if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    assign w_tick = (r_baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RX_IDLE;
            r_s_cnt       <= '0;
            r_n_cnt       <= '0;
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_byte_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_byte_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_state <= RX_START;
                        r_s_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (w_tick) begin
                        if (r_s_cnt == HALF_LAST) begin
                            r_s_cnt <= '0;
                            r_n_cnt <= '0;
                            // A start bit that is already high again at mid-bit was a glitch.
                            r_state <= r_sync2 ? RX_IDLE : RX_DATA;
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        if (r_s_cnt == FULL_LAST) begin
                            r_s_cnt <= '0;
                            r_shift <= {r_sync2, r_shift[DATA_SIZE-1:1]};
                            if (r_n_cnt == BIT_LAST) begin
                                r_state <= RX_STOP;
                            end else begin
                                r_n_cnt <= r_n_cnt + 1'b1;
                            end
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        if (r_s_cnt == FULL_LAST) begin
                            r_s_cnt <= '0;
                            if (r_sync2) begin
                                r_rx_data    <= r_shift;
                                r_byte_valid <= 1'b1;
                                r_state      <= RX_IDLE;
                            end else begin
                                r_frame_error <= 1'b1;
                                r_state       <= RX_BREAK;
                            end
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end
                end
                RX_BREAK: begin
                    if (r_sync2) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign rx_data     = r_rx_data;
    assign byte_valid  = r_byte_valid;
    assign frame_error = r_frame_error;
    assign rx_busy     = (r_state != RX_IDLE);
    assign state_dbg   = r_state;

endmodule

// File: rtl/uart_speed_receiver.sv
// Speed-record receiver: pairs a flagged high character with the following low
// character and presents the reassembled speed with a one-cycle valid strobe.
module uart_speed_receiver
    import uart_pkg::*;
#(
    parameter int WIDTH_SPEED = 14,
    parameter int DATA_SIZE   = 8,
    parameter int SAMPLE      = 16,
    parameter int BAUD_DVSR   = 271
) (
    input logic                  clk,
    input logic                  reset,
    uart_speed_receiver_if.slave bus
);
    if ((WIDTH_SPEED != 2 * PAYLOAD_BITS) || (DATA_SIZE != PAYLOAD_BITS + 1)) begin : g_width_check
        $error("uart_speed_receiver: WIDTH_SPEED must equal 2*(DATA_SIZE-1)");
    end

    logic [DATA_SIZE-1:0]    w_rx_data;
    logic                    w_byte_valid;
    logic                    w_frame_error;
    logic                    w_rx_busy;
    rx_state_t               w_rx_state;
    logic [PAYLOAD_BITS-1:0] w_payload;
    logic                    w_hdr;

    asm_state_t              r_asm;
    logic [PAYLOAD_BITS-1:0] r_hi;
    logic [WIDTH_SPEED-1:0]  r_speed;
    logic                    r_speed_valid;
    logic                    r_sync_error;

    uart_receiver #(
        .DATA_SIZE (DATA_SIZE),
        .SAMPLE    (SAMPLE),
        .BAUD_DVSR (BAUD_DVSR)
    ) u_rx (
        .clk            (clk),
        .reset          (reset),
        .serial_data_in (bus.serial_data_in),
        .rx_data        (w_rx_data),
        .byte_valid     (w_byte_valid),
        .frame_error    (w_frame_error),
        .rx_busy        (w_rx_busy),
        .state_dbg      (w_rx_state)
    );

    assign w_payload = w_rx_data[PAYLOAD_BITS-1:0];
    assign w_hdr     = w_rx_data[HDR_BIT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_asm         <= ASM_WAIT_HI;
            r_hi          <= '0;
            r_speed       <= '0;
            r_speed_valid <= 1'b0;
            r_sync_error  <= 1'b0;
        end else begin
            r_speed_valid <= 1'b0;
            r_sync_error  <= 1'b0;
            if (w_frame_error) begin
                // A corrupted character breaks the record silently; resync on the next high byte.
                r_asm <= ASM_WAIT_HI;
            end else if (w_byte_valid) begin
                case (r_asm)
                    ASM_WAIT_HI: begin
                        if (w_hdr) begin
                            r_hi  <= w_payload;
                            r_asm <= ASM_WAIT_LO;
                        end else begin
                            r_sync_error <= 1'b1;
                        end
                    end
                    ASM_WAIT_LO: begin
                        if (!w_hdr) begin
                            r_speed       <= WIDTH_SPEED'({r_hi, w_payload});
                            r_speed_valid <= 1'b1;
                            r_asm         <= ASM_WAIT_HI;
                        end else begin
                            r_sync_error <= 1'b1;
                            r_hi         <= w_payload;
                        end
                    end
                    default: begin
                        r_asm <= ASM_WAIT_HI;
                    end
                endcase
            end
        end
    end

    assign bus.speed          = r_speed;
    assign bus.speed_valid    = r_speed_valid;
    assign bus.frame_error    = w_frame_error;
    assign bus.sync_error     = r_sync_error;
    assign bus.rx_busy        = w_rx_busy;
    assign bus.byte_state_dbg = w_rx_state;
    assign bus.asm_state_dbg  = r_asm;

endmodule
